// File: rtl/issueint_sched_pkg.sv
// Purpose: shared constants for the integer issue queue: default tag/data
//          widths and the ALU opcode/funct codes used by dispatch and the ALU.
// Ports:   none (package).
package issueint_sched_pkg;

  localparam int unsigned DEF_TAG_W  = 6;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned OPC_W      = 6;

  // ALU opcode/funct codes (MIPS-style funct values, branches use opcode values)
  localparam logic [OPC_W-1:0] OP_ADD = 6'h20;
  localparam logic [OPC_W-1:0] OP_SUB = 6'h22;
  localparam logic [OPC_W-1:0] OP_AND = 6'h24;
  localparam logic [OPC_W-1:0] OP_OR  = 6'h25;
  localparam logic [OPC_W-1:0] OP_SLT = 6'h2a;
  localparam logic [OPC_W-1:0] OP_BEQ = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE = 6'h05;

endpackage

// File: rtl/issueint_pick.sv
// Purpose: lowest-index-first picker over the issue queue ready vector.
//          Purely combinational.
// Ports:   ready_i       - per-entry ready (valid & both operands ready)
//          grant_c_o     - one-hot grant of the oldest ready entry
//          idx_c_o       - binary index of the granted entry
//          any_ready_c_o - at least one entry is ready
module issueint_pick #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [DEPTH-1:0] ready_i,
  output logic [DEPTH-1:0] grant_c_o,
  output logic [IDX_W-1:0] idx_c_o,
  output logic             any_ready_c_o
);

  // Scan upward; the first ready entry found wins.
  always_comb begin
    logic found;
    grant_c_o     = '0;
    idx_c_o       = '0;
    any_ready_c_o = |ready_i;
    found         = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ready_i[i] && !found) begin
        found        = 1'b1;
        grant_c_o[i] = 1'b1;
        idx_c_o      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/issueint_sched.sv
// Purpose: integer issue queue + scheduler feeding the single-cycle ALU.
//          Collapsing queue (index 0 oldest), CDB wakeup with dispatch
//          bypass, oldest-ready select, registered issue port.
//          Optional macro ISSUEINT_PERF_CNT_EN adds issue/stall counters.
// Ports:   clk, reset (async, active-low)
//          dispatch_*      - op + tagged operands from dispatch
//          issueint_full   - no free entry, dispatch is dropped
//          cdb_valid/tag/data - result broadcast for wakeup
//          issue_stall     - ALU cannot take an op this cycle
//          flush           - discard all queued and issuing ops
//          issueint_*      - registered issue port to the ALU
//          issueint_issue_cnt/stall_cnt - perf counters (macro only)
module issueint_sched
  import issueint_sched_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = DEF_TAG_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dispatch_valid,
  input  logic [OPC_W-1:0]  dispatch_opcode,
  input  logic [DATA_W-1:0] dispatch_rsdata,
  input  logic [TAG_W-1:0]  dispatch_rstag,
  input  logic              dispatch_rsready,
  input  logic [DATA_W-1:0] dispatch_rtdata,
  input  logic [TAG_W-1:0]  dispatch_rttag,
  input  logic              dispatch_rtready,
  input  logic [TAG_W-1:0]  dispatch_rdtag,
  output logic              issueint_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              issue_stall,
  input  logic              flush,
  output logic              issueint_ready,
  output logic [OPC_W-1:0]  issueint_opcode,
  output logic [DATA_W-1:0] issueint_rsdata,
  output logic [DATA_W-1:0] issueint_rtdata,
  output logic [TAG_W-1:0]  issueint_rdtag
`ifdef ISSUEINT_PERF_CNT_EN
  ,
  output logic [31:0]       issueint_issue_cnt,
  output logic [31:0]       issueint_stall_cnt
`endif
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              v;
    logic [OPC_W-1:0]  op;
    logic [DATA_W-1:0] rsd;
    logic [TAG_W-1:0]  rst;
    logic              rsr;
    logic [DATA_W-1:0] rtd;
    logic [TAG_W-1:0]  rtt;
    logic              rtr;
    logic [TAG_W-1:0]  rd;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  entry_t            wk    [DEPTH];
  entry_t            sh    [DEPTH];
  entry_t            new_ent;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic [DEPTH-1:0]  rdy_vec, grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              any_ready;
  logic              issue_fire, disp_acc;
  logic [CNT_W-1:0]  wr_slot;
  logic [OPC_W-1:0]  sel_op;
  logic [DATA_W-1:0] sel_rsd, sel_rtd;
  logic [TAG_W-1:0]  sel_rd;

  logic              ready_q;
  logic [OPC_W-1:0]  op_q;
  logic [DATA_W-1:0] rsd_q, rtd_q;
  logic [TAG_W-1:0]  rd_q;

  // Select works on registered state only, so this cycle's wakeup is not seen.
  always_comb begin
    rdy_vec = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      rdy_vec[i] = ent_q[i].v & ent_q[i].rsr & ent_q[i].rtr;
    end
  end

  issueint_pick #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_pick (
    .ready_i       (rdy_vec),
    .grant_c_o     (grant),
    .idx_c_o       (pick_idx),
    .any_ready_c_o (any_ready)
  );

  assign issue_fire = any_ready & ~issue_stall & ~flush;
  assign disp_acc   = dispatch_valid & ~full_q & ~flush;
  // An issue on the same edge frees the slot below the current tail.
  assign wr_slot    = count_q - CNT_W'(issue_fire);

  // Fields of the granted entry for the output registers.
  always_comb begin
    sel_op  = '0;
    sel_rsd = '0;
    sel_rtd = '0;
    sel_rd  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (grant[i]) begin
        sel_op  = ent_q[i].op;
        sel_rsd = ent_q[i].rsd;
        sel_rtd = ent_q[i].rtd;
        sel_rd  = ent_q[i].rd;
      end
    end
  end

  // CDB wakeup of queued operands.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      wk[i] = ent_q[i];
      if (cdb_valid && ent_q[i].v && !ent_q[i].rsr && (ent_q[i].rst == cdb_tag)) begin
        wk[i].rsd = cdb_data;
        wk[i].rsr = 1'b1;
      end
      if (cdb_valid && ent_q[i].v && !ent_q[i].rtr && (ent_q[i].rtt == cdb_tag)) begin
        wk[i].rtd = cdb_data;
        wk[i].rtr = 1'b1;
      end
    end
  end

  // Collapsed view: every entry moved down one index, top slot emptied.
  always_comb begin
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      sh[i] = wk[i+1];
    end
    sh[DEPTH-1] = '0;
  end

  // Incoming entry, with same-cycle CDB bypass on unready operands.
  always_comb begin
    new_ent     = '0;
    new_ent.v   = 1'b1;
    new_ent.op  = dispatch_opcode;
    new_ent.rsd = dispatch_rsdata;
    new_ent.rst = dispatch_rstag;
    new_ent.rsr = dispatch_rsready;
    new_ent.rtd = dispatch_rtdata;
    new_ent.rtt = dispatch_rttag;
    new_ent.rtr = dispatch_rtready;
    new_ent.rd  = dispatch_rdtag;
    if (cdb_valid && !dispatch_rsready && (dispatch_rstag == cdb_tag)) begin
      new_ent.rsd = cdb_data;
      new_ent.rsr = 1'b1;
    end
    if (cdb_valid && !dispatch_rtready && (dispatch_rttag == cdb_tag)) begin
      new_ent.rtd = cdb_data;
      new_ent.rtr = 1'b1;
    end
  end

  // Queue next state: wakeup, collapse on issue, dispatch write, flush.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_d[i] = wk[i];
      if (issue_fire && (IDX_W'(i) >= pick_idx)) begin
        ent_d[i] = sh[i];
      end
      if (disp_acc && (CNT_W'(i) == wr_slot)) begin
        ent_d[i] = new_ent;
      end
      if (flush) begin
        ent_d[i] = '0;
      end
    end
    count_d = flush ? '0 : (count_q - CNT_W'(issue_fire) + CNT_W'(disp_acc));
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= '0;
      end
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Issue port; payload is only meaningful while ready_q is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b0;
      op_q    <= '0;
      rsd_q   <= '0;
      rtd_q   <= '0;
      rd_q    <= '0;
    end else begin
      ready_q <= issue_fire;
      if (issue_fire) begin
        op_q  <= sel_op;
        rsd_q <= sel_rsd;
        rtd_q <= sel_rtd;
        rd_q  <= sel_rd;
      end
    end
  end

  assign issueint_full   = full_q;
  assign issueint_ready  = ready_q;
  assign issueint_opcode = op_q;
  assign issueint_rsdata = rsd_q;
  assign issueint_rtdata = rtd_q;
  assign issueint_rdtag  = rd_q;

`ifdef ISSUEINT_PERF_CNT_EN
  logic [31:0] issue_cnt_q, stall_cnt_q;

  // Free-running counters; survive flush, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue_fire) begin
        issue_cnt_q <= issue_cnt_q + 32'd1;
      end
      if (any_ready && issue_stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign issueint_issue_cnt = issue_cnt_q;
  assign issueint_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issueint_sched.sv
// Purpose: self-checking bench for issueint_sched. A queue-based model
//          tracks expected issue-port and full behaviour every cycle;
//          directed scenarios add hand-computed literal expectations.
module tb_issueint_sched;
  import issueint_sched_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dispatch_valid = 1'b0;
  logic [5:0]  dispatch_opcode = '0;
  logic [31:0] dispatch_rsdata = '0;
  logic [5:0]  dispatch_rstag = '0;
  logic        dispatch_rsready = 1'b0;
  logic [31:0] dispatch_rtdata = '0;
  logic [5:0]  dispatch_rttag = '0;
  logic        dispatch_rtready = 1'b0;
  logic [5:0]  dispatch_rdtag = '0;
  logic        issueint_full;
  logic        cdb_valid = 1'b0;
  logic [5:0]  cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic        issue_stall = 1'b0;
  logic        flush = 1'b0;
  logic        issueint_ready;
  logic [5:0]  issueint_opcode;
  logic [31:0] issueint_rsdata;
  logic [31:0] issueint_rtdata;
  logic [5:0]  issueint_rdtag;
`ifdef ISSUEINT_PERF_CNT_EN
  logic [31:0] issueint_issue_cnt;
  logic [31:0] issueint_stall_cnt;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  issueint_sched #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .dispatch_valid   (dispatch_valid),
    .dispatch_opcode  (dispatch_opcode),
    .dispatch_rsdata  (dispatch_rsdata),
    .dispatch_rstag   (dispatch_rstag),
    .dispatch_rsready (dispatch_rsready),
    .dispatch_rtdata  (dispatch_rtdata),
    .dispatch_rttag   (dispatch_rttag),
    .dispatch_rtready (dispatch_rtready),
    .dispatch_rdtag   (dispatch_rdtag),
    .issueint_full    (issueint_full),
    .cdb_valid        (cdb_valid),
    .cdb_tag          (cdb_tag),
    .cdb_data         (cdb_data),
    .issue_stall      (issue_stall),
    .flush            (flush),
    .issueint_ready   (issueint_ready),
    .issueint_opcode  (issueint_opcode),
    .issueint_rsdata  (issueint_rsdata),
    .issueint_rtdata  (issueint_rtdata),
    .issueint_rdtag   (issueint_rdtag)
`ifdef ISSUEINT_PERF_CNT_EN
    ,
    .issueint_issue_cnt (issueint_issue_cnt),
    .issueint_stall_cnt (issueint_stall_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act === exp_v) passes++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp_v, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [5:0]  op;
    logic [31:0] rsd;
    logic [5:0]  rst;
    bit          rsr;
    logic [31:0] rtd;
    logic [5:0]  rtt;
    bit          rtr;
    logic [5:0]  rd;
  } m_ent_t;

  m_ent_t      mq[$];
  m_ent_t      m_new;
  int          m_sel;
  bit          m_was_full;
  bit          exp_ready = 1'b0;
  bit          exp_full = 1'b0;
  logic [5:0]  exp_op = '0;
  logic [31:0] exp_rs = '0;
  logic [31:0] exp_rt = '0;
  logic [5:0]  exp_rd = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      exp_ready = 0; exp_full = 0;
      exp_op = '0; exp_rs = '0; exp_rt = '0; exp_rd = '0;
    end else if (flush) begin
      mq.delete();
      exp_ready = 0; exp_full = 0;
    end else begin
      m_sel = -1;
      foreach (mq[i]) if (m_sel < 0 && mq[i].rsr && mq[i].rtr) m_sel = i;
      m_was_full = (mq.size() == DEPTH);
      if (cdb_valid) begin
        foreach (mq[i]) begin
          if (!mq[i].rsr && mq[i].rst == cdb_tag) begin mq[i].rsd = cdb_data; mq[i].rsr = 1; end
          if (!mq[i].rtr && mq[i].rtt == cdb_tag) begin mq[i].rtd = cdb_data; mq[i].rtr = 1; end
        end
      end
      if (m_sel >= 0 && !issue_stall) begin
        exp_ready = 1;
        exp_op = mq[m_sel].op; exp_rs = mq[m_sel].rsd;
        exp_rt = mq[m_sel].rtd; exp_rd = mq[m_sel].rd;
        mq.delete(m_sel);
      end else begin
        exp_ready = 0;
      end
      if (dispatch_valid && !m_was_full) begin
        m_new.op = dispatch_opcode; m_new.rd = dispatch_rdtag;
        m_new.rsd = dispatch_rsdata; m_new.rst = dispatch_rstag; m_new.rsr = dispatch_rsready;
        m_new.rtd = dispatch_rtdata; m_new.rtt = dispatch_rttag; m_new.rtr = dispatch_rtready;
        if (cdb_valid && !m_new.rsr && m_new.rst == cdb_tag) begin m_new.rsd = cdb_data; m_new.rsr = 1; end
        if (cdb_valid && !m_new.rtr && m_new.rtt == cdb_tag) begin m_new.rtd = cdb_data; m_new.rtr = 1; end
        mq.push_back(m_new);
      end
      exp_full = (mq.size() == DEPTH);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    wait (reset === 1'b1);
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("m_ready", 64'(issueint_ready), 64'(exp_ready));
        chk("m_full", 64'(issueint_full), 64'(exp_full));
        if (exp_ready) begin
          chk("m_opcode", 64'(issueint_opcode), 64'(exp_op));
          chk("m_rsdata", 64'(issueint_rsdata), 64'(exp_rs));
          chk("m_rtdata", 64'(issueint_rtdata), 64'(exp_rt));
          chk("m_rdtag", 64'(issueint_rdtag), 64'(exp_rd));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic disp(input logic [5:0] op, input logic [31:0] rsd, input logic [5:0] rst,
                      input logic rsr, input logic [31:0] rtd, input logic [5:0] rtt,
                      input logic rtr, input logic [5:0] rd);
    dispatch_valid = 1'b1; dispatch_opcode = op;
    dispatch_rsdata = rsd; dispatch_rstag = rst; dispatch_rsready = rsr;
    dispatch_rtdata = rtd; dispatch_rttag = rtt; dispatch_rtready = rtr;
    dispatch_rdtag = rd;
  endtask

  task automatic cdb(input logic [5:0] t, input logic [31:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
  endtask

  // Advance one edge; one-shot inputs drop after it.
  task automatic tick();
    @(posedge clk);
    #2;
    dispatch_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_ready", 64'(issueint_ready), 64'd0);
    chk("rst_full", 64'(issueint_full), 64'd0);
    chk("rst_rdtag", 64'(issueint_rdtag), 64'd0);
    reset = 1'b1;
    tick();

    // Both operands ready: issues two edges after dispatch, one-cycle pulse.
    disp(OP_ADD, 32'd5, 6'd0, 1, 32'd7, 6'd0, 1, 6'd3);
    tick();
    chk("add_not_yet", 64'(issueint_ready), 64'd0);
    tick();
    chk("add_ready", 64'(issueint_ready), 64'd1);
    chk("add_opcode", 64'(issueint_opcode), 64'(OP_ADD));
    chk("add_rs", 64'(issueint_rsdata), 64'd5);
    chk("add_rt", 64'(issueint_rtdata), 64'd7);
    chk("add_rd", 64'(issueint_rdtag), 64'd3);
    tick();
    chk("add_pulse", 64'(issueint_ready), 64'd0);

    // rt waits on tag 9.
    disp(OP_SUB, 32'd1, 6'd0, 1, 32'd0, 6'd9, 0, 6'd4);
    tick(); tick();
    chk("sub_wait", 64'(issueint_ready), 64'd0);
    cdb(6'd9, 32'h10);
    tick();
    chk("sub_wake_edge", 64'(issueint_ready), 64'd0);
    tick();
    chk("sub_ready", 64'(issueint_ready), 64'd1);
    chk("sub_rt", 64'(issueint_rtdata), 64'h10);
    chk("sub_opcode", 64'(issueint_opcode), 64'(OP_SUB));
    tick();

    // Oldest-first under stall, plus dispatch concurrent with issue.
    issue_stall = 1'b1;
    disp(OP_AND, 32'd1, 6'd0, 1, 32'd2, 6'd0, 1, 6'd20); tick();
    disp(OP_OR,  32'd0, 6'd30, 0, 32'd3, 6'd0, 1, 6'd21); tick();
    chk("stall0", 64'(issueint_ready), 64'd0);
    disp(OP_BEQ, 32'd4, 6'd0, 1, 32'd4, 6'd0, 1, 6'd22); tick();
    chk("stall1", 64'(issueint_ready), 64'd0);
    tick();
    chk("stall2", 64'(issueint_ready), 64'd0);
    tick();
    chk("stall3", 64'(issueint_ready), 64'd0);
    issue_stall = 1'b0;
    disp(OP_SLT, 32'd8, 6'd0, 1, 32'd9, 6'd0, 1, 6'd23);
    tick();
    chk("order0_rd", 64'(issueint_rdtag), 64'd20);
    tick();
    chk("order1_rd", 64'(issueint_rdtag), 64'd22);
    tick();
    chk("order2_rd", 64'(issueint_rdtag), 64'd23);
    tick();
    chk("order_idle", 64'(issueint_ready), 64'd0);
    cdb(6'd30, 32'h30);
    tick(); tick();
    chk("late_rd", 64'(issueint_rdtag), 64'd21);
    chk("late_rs", 64'(issueint_rsdata), 64'h30);
    tick();

    // Dispatch bypass from a same-cycle broadcast.
    disp(OP_OR, 32'hdead, 6'd4, 0, 32'd2, 6'd0, 1, 6'd5);
    cdb(6'd4, 32'hAA);
    tick(); tick();
    chk("byp_ready", 64'(issueint_ready), 64'd1);
    chk("byp_rs", 64'(issueint_rsdata), 64'hAA);
    tick();

    // Fill, drop while full, wake entry 2.
    for (int i = 0; i < 4; i++) begin
      disp(OP_ADD, 32'd0, 6'(20 + i), 0, 32'd1, 6'd0, 1, 6'(10 + i));
      tick();
    end
    chk("fill_full", 64'(issueint_full), 64'd1);
    disp(OP_ADD, 32'd1, 6'd0, 1, 32'd1, 6'd0, 1, 6'd14);
    tick();
    chk("drop_full", 64'(issueint_full), 64'd1);
    chk("drop_ready", 64'(issueint_ready), 64'd0);
    cdb(6'd22, 32'h22);
    tick();
    chk("fill_wake_full", 64'(issueint_full), 64'd1);
    tick();
    chk("fill_issue_rd", 64'(issueint_rdtag), 64'd12);
    chk("fill_issue_rs", 64'(issueint_rsdata), 64'h22);
    chk("fill_unfull", 64'(issueint_full), 64'd0);
    tick();

    // Flush with three stuck entries and a ready op about to issue.
    disp(OP_BNE, 32'd1, 6'd0, 1, 32'd2, 6'd0, 1, 6'd40);
    tick();
    chk("pre_flush_full", 64'(issueint_full), 64'd1);
    flush = 1'b1;
    tick();
    chk("flush_ready", 64'(issueint_ready), 64'd0);
    chk("flush_full", 64'(issueint_full), 64'd0);
    cdb(6'd20, 32'h1);
    tick(); tick(); tick();
    chk("post_flush_idle", 64'(issueint_ready), 64'd0);

    // Asynchronous reset mid-stream.
    disp(OP_ADD, 32'd11, 6'd0, 1, 32'd12, 6'd0, 1, 6'd33);
    tick(); tick();
    chk("pre_rst_ready", 64'(issueint_ready), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_ready", 64'(issueint_ready), 64'd0);
    chk("async_rdtag", 64'(issueint_rdtag), 64'd0);
    chk("async_rsdata", 64'(issueint_rsdata), 64'd0);
    tick();
    reset = 1'b1;
    tick(); tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
